fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first instruction fetched after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_addr  output  32  word index to instruction memory: {2'b00, pc[31:2]}.
REQ-005 SHALL have port imem_re  output  1  instruction memory read enable.
REQ-006 SHALL have port imem_rdata  input  32  instruction word; valid combinationally in the same cycle as imem_re/imem_addr.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump taken; load new PC.
REQ-008 SHALL have port redirect_target  input  32  byte address of the redirect destination.
REQ-009 SHALL have port if_valid  output  1  if_instr/if_pc hold a valid fetched instruction.
REQ-010 SHALL have port if_ready  input  1  decode stage accepts the instruction this cycle.
REQ-011 SHALL have port if_instr  output  32  registered instruction word.
REQ-012 SHALL have port if_pc  output  32  byte address of if_instr.
REQ-013 SHALL have port fault  output  1  misaligned-redirect fault flag (see Configuration).

Function
REQ-014 SHALL hold an internal 32-bit byte-addressed pc register; increments are +4, modulo 2^32.
REQ-015 SHALL implement states IDLE, FETCH, FAULT; IDLE->FETCH unconditionally one cycle after reset release (one bubble, no fetch in IDLE).
REQ-016 SHALL define fetch_go = (state==FETCH) && !redirect_valid && (!if_valid || if_ready).
REQ-017 SHALL drive imem_re = fetch_go combinationally; imem_addr always reflects current pc.
REQ-018 On fetch_go at a rising edge: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (one-cycle latency, one instruction per cycle when if_ready stays 1).
REQ-019 When if_valid=1 and if_ready=0: if_instr, if_pc, if_valid, pc SHALL hold; imem_re=0.
REQ-020 When if_valid=1, if_ready=1, no fetch_go (e.g. IDLE): if_valid<=0.
REQ-021 redirect_valid SHALL have highest priority: at the edge, pc<=redirect_target, if_valid<=0 (flush), no capture; applies in any state incl. IDLE.
REQ-022 Redirect while stalled (if_valid=1, if_ready=0) SHALL still flush; the held instruction is discarded.
REQ-023 Back-to-back redirects SHALL each overwrite pc; only the last one takes effect before fetch resumes.
REQ-024 First fetch after a redirect SHALL occur in the cycle following the redirect (one-cycle bubble).

Reset
REQ-025 On rst_n=0, asynchronously: pc=RESET_PC, state=IDLE, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=RESET_PC, fault=0; imem_re=0 while in reset.
REQ-026 Reset asserted mid-stall or mid-fault SHALL abandon all state; no instruction output until the post-reset IDLE bubble has elapsed.

Configuration
REQ-027 Macro FETCH_MISALIGN_CHK_EN defined: redirect with redirect_target[1:0]!=0 SHALL move to FAULT, set fault=1, if_valid<=0, pc<=redirect_target; FAULT keeps imem_re=0, exits only by reset or an aligned redirect (->FETCH, fault<=0).
REQ-028 Macro FETCH_MISALIGN_CHK_EN undefined: FAULT state absent, fault tied 0, redirect loads {redirect_target[31:2],2'b00}.

Verification
REQ-029 Reset release, if_ready=1, mem[0]=32'h0030_2183, mem[1]=32'h0070_2203 -> cycle 1 bubble; then if_pc=0/if_instr=32'h0030_2183, next cycle if_pc=4/if_instr=32'h0070_2203.
REQ-030 if_ready=0 for 3 cycles while if_valid=1, if_pc=8 -> if_pc stays 8, imem_re=0 throughout; if_ready=1 -> next if_pc=12.
REQ-031 redirect_valid=1, target=32'h0000_0010 while if_pc=4 stalled -> if_valid=0 next cycle; following cycle if_pc=16, if_instr=mem[4].
REQ-032 With FETCH_MISALIGN_CHK_EN: redirect target=32'h0000_0012 -> fault=1, if_valid=0, imem_re=0; then target=32'h0000_0020 -> fault=0, next output if_pc=32. Without macro: target 32'h12 -> if_pc=16.
REQ-033 rst_n pulsed low mid-stream at if_pc=20 -> outputs immediately at reset values; after release, bubble then if_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: pc register, single-entry output buffer with valid/ready
// handshake and redirect flush. Define FETCH_MISALIGN_CHK_EN to trap misaligned redirects.
//
// state | meaning
// IDLE  | one-cycle bubble after reset, no fetch issued
// FETCH | fetching one instruction per cycle when downstream accepts
// FAULT | misaligned redirect seen; fetch halted until aligned redirect or reset
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_re,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_CHK_EN
    typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;
`else
    typedef enum logic [0:0] {IDLE, FETCH} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        fetch_go;

`ifdef FETCH_MISALIGN_CHK_EN
    logic fault_q, fault_d;
`endif

    assign fetch_go  = (state_q == FETCH) && !redirect_valid && (!if_valid_q || if_ready);
    assign imem_re   = fetch_go;
    assign imem_addr = {2'b00, pc_q[31:2]};
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;

`ifdef FETCH_MISALIGN_CHK_EN
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
`ifdef FETCH_MISALIGN_CHK_EN
        fault_d    = fault_q;
`endif
        if (redirect_valid) begin
            // Redirect wins over everything, including a stalled instruction.
            if_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            pc_d = redirect_target;
            if (redirect_target[1:0] != 2'b00) begin
                state_d = FAULT;
                fault_d = 1'b1;
            end else begin
                state_d = FETCH;
                fault_d = 1'b0;
            end
`else
            pc_d    = redirect_target & 32'hFFFF_FFFC;
            state_d = FETCH;
`endif
        end else begin
            if (state_q == IDLE) begin
                state_d = FETCH;
            end
            if (fetch_go) begin
                if_instr_d = imem_rdata;
                if_pc_d    = pc_q;
                if_valid_d = 1'b1;
                pc_d       = pc_q + 32'd4;
            end else if (if_valid_q && if_ready) begin
                if_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= NOP;
            if_pc_q    <= RESET_PC;
`ifdef FETCH_MISALIGN_CHK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
`ifdef FETCH_MISALIGN_CHK_EN
            fault_q    <= fault_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: bubble, streaming, stall, redirect flush,
// misaligned redirect (both builds), pc wrap and mid-stream reset.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_re;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fault;

    logic [31:0] mem [64];
    int total = 0;
    int bad   = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_re         (imem_re),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .fault           (fault)
    );

    assign imem_rdata = mem[imem_addr[5:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_instr"}, if_instr, 32'h0000_0013);
        chk({tag, "_pc"}, if_pc, 32'h0000_0000);
        chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
        chk({tag, "_re"}, {31'd0, imem_re}, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h0030_2183;
        mem[1] = 32'h0070_2203;

        rst_n = 1'b1;
        if_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;
        #2 rst_n = 1'b0;
        #20;
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // post-reset bubble, then first fetch issued
        step();
        chk("bubble_valid", {31'd0, if_valid}, 32'd0);
        chk("bubble_re", {31'd0, imem_re}, 32'd1);
        step();
        chk("f0_valid", {31'd0, if_valid}, 32'd1);
        chk("f0_pc", if_pc, 32'h0);
        chk("f0_instr", if_instr, 32'h0030_2183);
        step();
        chk("f1_pc", if_pc, 32'h4);
        chk("f1_instr", if_instr, 32'h0070_2203);
        step();
        chk("f2_pc", if_pc, 32'h8);

        // 3-cycle stall at if_pc=8
        if_ready = 1'b0;
        #1 chk("stall_re0", {31'd0, imem_re}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", if_pc, 32'h8);
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_re", {31'd0, imem_re}, 32'd0);
        end
        if_ready = 1'b1;
        step();
        chk("unstall_pc", if_pc, 32'hC);
        chk("unstall_instr", if_instr, 32'hA000_0003);

        // redirect while stalled flushes held instruction
        if_ready = 1'b0;
        step();
        chk("stall2_pc", if_pc, 32'hC);
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0010;
        if_ready = 1'b1;
        #1 chk("redir_re", {31'd0, imem_re}, 32'd0);
        step();
        chk("redir_flush", {31'd0, if_valid}, 32'd0);
        redirect_valid = 1'b0;
        step();
        chk("redir_pc", if_pc, 32'h10);
        chk("redir_instr", if_instr, 32'hA000_0004);

        // back-to-back redirects: last one wins
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0100;
        step();
        chk("b2b_flush", {31'd0, if_valid}, 32'd0);
        redirect_target = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        step();
        chk("b2b_pc", if_pc, 32'h40);
        chk("b2b_instr", if_instr, 32'hA000_0010);

        // misaligned redirect
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0012;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_valid", {31'd0, if_valid}, 32'd0);
        chk("mis_re", {31'd0, imem_re}, 32'd0);
        step();
        chk("mis_hold_fault", {31'd0, fault}, 32'd1);
        chk("mis_hold_re", {31'd0, imem_re}, 32'd0);
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0020;
        step();
        redirect_valid = 1'b0;
        chk("mis_clear", {31'd0, fault}, 32'd0);
        step();
        chk("mis_pc", if_pc, 32'h20);
        chk("mis_instr", if_instr, 32'hA000_0008);
`else
        chk("mis_fault", {31'd0, fault}, 32'd0);
        chk("mis_valid", {31'd0, if_valid}, 32'd0);
        step();
        chk("mis_pc", if_pc, 32'h10);
        chk("mis_instr", if_instr, 32'hA000_0004);
`endif

        // pc wraps modulo 2^32
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        chk("wrap_top_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_top_instr", if_instr, 32'hA000_003F);
        step();
        chk("wrap_pc", if_pc, 32'h0);

        // run to if_pc=20 then reset mid-stream
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0014;
        step();
        redirect_valid = 1'b0;
        step();
        chk("pre_rst_pc", if_pc, 32'h14);
        rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        #1 rst_n = 1'b1;
        step();
        chk("midrst_bubble", {31'd0, if_valid}, 32'd0);
        step();
        chk("midrst_pc", if_pc, 32'h0);
        chk("midrst_instr", if_instr, 32'h0030_2183);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
